line_buffer_ctrl: RTL and testbench

Sequencer for the 3-line BRAM window buffer in the denoise filter path. It accepts the incoming pixel stream handshake and drives the buffer's write enable, column and row-slot select, and its read enable and column. It rotates the three physical line slots and emits a window-valid stream with SOF/EOL markers and the top-row slot index, so the downstream 3×3 filter can reorder the buffer outputs. Pixel data goes directly from source to buffer; this block carries control only.

---
 rtl/denoise_pkg.sv | 20 ++
 rtl/line_seq_counter.sv | 45 ++++
 rtl/line_buffer_ctrl.sv | 166 ++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/denoise_pkg.sv
// Shared types and helpers for the denoise filter path: line-buffer sequencer
// states, default line width and slot rotation.
package denoise_pkg;

  localparam int LINE_WIDTH_DEF = 1920;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL0,
    ST_FILL1,
    ST_RUN,
    ST_FLUSH
  } lb_state_e;

  // Next physical line slot in the three-slot rotation.
  function automatic logic [1:0] mod3_inc(input logic [1:0] r);
    return (r == 2'd2) ? 2'd0 : r + 2'd1;
  endfunction

endpackage

// File: rtl/line_seq_counter.sv
// Write-column counter for the line buffer: tracks the column of the next
// pixel, flags the end of a line and lines that are too short or too long.
module line_seq_counter
  import denoise_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int X_W        = 11
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           inc,
  input  logic           restart,
  input  logic           eol,
  output logic [X_W-1:0] x,
  output logic           mid_line,
  output logic           line_end,
  output logic           err_len
);

  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);

  logic [X_W-1:0] cnt;
  logic           at_last;

  // A restarting pixel is column 0 regardless of where the old line stood.
  assign x        = restart ? '0 : cnt;
  assign at_last  = (x == X_LAST);
  assign mid_line = (cnt != '0);
  assign line_end = inc && (eol || at_last);
  // Short: EOL before the last column. Long: last column reached without EOL.
  assign err_len  = inc && (eol != at_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (line_end) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= x + 1'b1;
    end else if (restart) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the 3-line window buffer: drives buffer write/read addressing,
// rotates the line slots and emits the window-valid stream with markers.
module line_buffer_ctrl
  import denoise_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int X_W        = 11
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           s_valid,
  input  logic           s_sof,
  input  logic           s_eol,
  output logic           s_ready,
  input  logic           m_ready,
  output logic           en_wr,
  output logic [X_W-1:0] write_x,
  output logic [1:0]     write_row,
  output logic           en_rd,
  output logic [X_W-1:0] read_x,
  output logic           win_valid,
  output logic           win_sof,
  output logic           win_eol,
  output logic [1:0]     row_top,
  output logic           err_line
);

  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);

  lb_state_e  state, state_cur, state_nxt;
  logic [1:0] row_q, row_cur, row_nxt;
  logic       drop_q, drop_cur, drop_nxt;
  logic       first_q, first_nxt;
  logic       rdy_q;
  logic       xfer, sof_x, hold_win;
  logic       line_end, err_len, mid_line;

  assign hold_win = win_valid && !m_ready;

  always_comb begin
    s_ready = 1'b0;
    if (rdy_q) begin
      case (state)
        ST_RUN:   s_ready = !hold_win;
        ST_FLUSH: s_ready = 1'b0;
        default:  s_ready = 1'b1;
      endcase
    end
  end

  assign xfer  = s_valid && s_ready;
  assign sof_x = xfer && s_sof;

  // SOF restarts the frame from any state; everything below sees the restarted view.
  assign state_cur = sof_x ? ST_FILL0 : state;
  assign row_cur   = sof_x ? 2'd0 : row_q;
  assign drop_cur  = sof_x ? 1'b0 : drop_q;

  assign en_wr     = xfer && !drop_cur && (state_cur inside {ST_FILL0, ST_FILL1, ST_RUN});
  assign write_row = row_cur;

  line_seq_counter #(
    .LINE_WIDTH (LINE_WIDTH),
    .X_W        (X_W)
  ) u_col (
    .clk      (clk),
    .rstn     (rstn),
    .inc      (en_wr),
    .restart  (sof_x),
    .eol      (s_eol),
    .x        (write_x),
    .mid_line (mid_line),
    .line_end (line_end),
    .err_len  (err_len)
  );

  // Reads trail writes by one column; FLUSH picks up the last column.
  always_comb begin
    en_rd  = 1'b0;
    read_x = (write_x == '0) ? '0 : write_x - 1'b1;
    if (state_cur == ST_FLUSH) begin
      en_rd  = !hold_win;
      read_x = X_LAST;
    end else if (state_cur == ST_RUN) begin
      en_rd = en_wr && (write_x != '0);
    end
  end

  always_comb begin
    state_nxt = state_cur;
    row_nxt   = row_cur;
    drop_nxt  = drop_cur;
    first_nxt = sof_x ? 1'b0 : first_q;
    if (line_end && !s_eol) begin
      drop_nxt = 1'b1;
    end else if (xfer && drop_cur && s_eol) begin
      drop_nxt = 1'b0;
    end
    case (state_cur)
      ST_FILL0: if (line_end) begin
        state_nxt = ST_FILL1;
        row_nxt   = mod3_inc(row_cur);
      end
      ST_FILL1: if (line_end) begin
        state_nxt = ST_RUN;
        row_nxt   = mod3_inc(row_cur);
        first_nxt = 1'b1;
      end
      ST_RUN: if (line_end) begin
        state_nxt = ST_FLUSH;
      end
      ST_FLUSH: if (en_rd) begin
        state_nxt = ST_RUN;
        row_nxt   = mod3_inc(row_cur);
        first_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      row_q   <= 2'd0;
      drop_q  <= 1'b0;
      first_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_q   <= row_nxt;
      drop_q  <= drop_nxt;
      first_q <= first_nxt;
      rdy_q   <= 1'b1;
    end
  end

  // Window stage: one cycle behind en_rd to match the buffer read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid <= 1'b0;
      win_sof   <= 1'b0;
      win_eol   <= 1'b0;
      row_top   <= 2'd0;
      err_line  <= 1'b0;
    end else begin
      if (en_rd) begin
        win_valid <= 1'b1;
        win_sof   <= first_q && (state == ST_RUN) && (write_x == X_ONE);
        win_eol   <= (state == ST_FLUSH);
        row_top   <= mod3_inc(row_cur);
      end else begin
        if (m_ready) begin
          win_valid <= 1'b0;
          win_sof   <= 1'b0;
          win_eol   <= 1'b0;
        end
        if (sof_x) begin
          row_top <= 2'd0;
        end
      end
      err_line <= err_len || (sof_x && mid_line);
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: line/frame-level reference model
// compared every cycle, plus literal per-scenario window and error counts.
module tb_line_buffer_ctrl;

  localparam int LW = 8;
  localparam int XW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0, m_ready = 1'b1;
  logic          s_ready, en_wr, en_rd, win_valid, win_sof, win_eol, err_line;
  logic [XW-1:0] write_x, read_x;
  logic [1:0]    write_row, row_top;

  line_buffer_ctrl #(.LINE_WIDTH(LW), .X_W(XW)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_sof(s_sof), .s_eol(s_eol),
    .s_ready(s_ready), .m_ready(m_ready), .en_wr(en_wr), .write_x(write_x),
    .write_row(write_row), .en_rd(en_rd), .read_x(read_x), .win_valid(win_valid),
    .win_sof(win_sof), .win_eol(win_eol), .row_top(row_top), .err_line(err_line)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position in lines/columns, pending flush, current window.
  bit m_rdy = 0, m_in_frame = 0, m_drop = 0, m_flush = 0;
  bit m_wv = 0, m_wsof = 0, m_weol = 0, m_err = 0;
  int m_line = 0, m_col = 0, m_top = 0;

  // Observed statistics per scenario.
  int win_cnt = 0, sof_cnt = 0, eol_cnt = 0, err_cnt = 0, held_cnt = 0, top_n = 0;
  int top_seq [0:7];

  always @(negedge clk) begin
    bit ready, xfer, sof, wr, last, ldone, rd, err, fl, edrop, ein;
    int ecol, eline, top;
    if (!rstn) begin
      check("rst_s_ready", s_ready, 0);
      check("rst_en_wr", en_wr, 0);
      check("rst_en_rd", en_rd, 0);
      check("rst_win_valid", win_valid, 0);
      check("rst_win_sof", win_sof, 0);
      check("rst_win_eol", win_eol, 0);
      check("rst_err_line", err_line, 0);
      check("rst_write_x", write_x, 0);
      check("rst_read_x", read_x, 0);
      check("rst_write_row", write_row, 0);
      check("rst_row_top", row_top, 0);
      m_rdy = 0; m_in_frame = 0; m_drop = 0; m_flush = 0;
      m_wv = 0; m_wsof = 0; m_weol = 0; m_err = 0;
      m_line = 0; m_col = 0; m_top = 0;
    end else begin
      fl    = m_flush;
      ready = m_rdy && !fl && (!(m_in_frame && m_line >= 2) || m_ready || !m_wv);
      xfer  = s_valid && ready;
      sof   = xfer && s_sof;
      ecol  = sof ? 0 : m_col;
      eline = sof ? 0 : m_line;
      edrop = sof ? 1'b0 : m_drop;
      ein   = m_in_frame || sof;
      wr    = xfer && ein && !edrop;
      last  = (ecol == LW - 1);
      ldone = wr && (s_eol || last);
      err   = (wr && (s_eol != last)) || (sof && m_col != 0);
      rd    = fl ? (m_ready || !m_wv) : (wr && eline >= 2 && ecol >= 1);
      top   = (eline >= 2) ? (eline - 2) % 3 : 0;

      check("s_ready", s_ready, ready);
      check("en_wr", en_wr, wr);
      check("en_rd", en_rd, rd);
      check("win_valid", win_valid, m_wv);
      check("win_sof", win_sof, m_wsof);
      check("win_eol", win_eol, m_weol);
      check("err_line", err_line, m_err);
      check("row_top", row_top, m_top);
      if (wr) begin
        check("write_x", write_x, ecol);
        check("write_row", write_row, eline % 3);
      end
      if (rd) check("read_x", read_x, fl ? LW - 1 : ecol - 1);

      if (win_valid && m_ready) begin
        win_cnt++;
        if (win_sof) sof_cnt++;
        if (win_eol) begin
          top_seq[top_n % 8] = row_top;
          top_n++;
          eol_cnt++;
        end
      end
      if (win_valid && !m_ready) held_cnt++;
      if (err_line) err_cnt++;

      m_in_frame = ein; m_line = eline; m_col = ecol; m_drop = edrop;
      if (ldone) begin
        m_col = 0;
        if (!s_eol) m_drop = 1;
        if (eline >= 2) m_flush = 1;
        else m_line = eline + 1;
      end else if (wr) begin
        m_col = ecol + 1;
      end else if (xfer && ein && edrop && s_eol) begin
        m_drop = 0;
      end
      if (fl && rd) begin
        m_flush = 0;
        m_line  = m_line + 1;
      end
      if (rd) begin
        m_wv = 1; m_wsof = !fl && eline == 2 && ecol == 1; m_weol = fl; m_top = top;
      end else begin
        if (m_ready) begin m_wv = 0; m_wsof = 0; m_weol = 0; end
        if (sof) m_top = 0;
      end
      m_err = err;
      m_rdy = 1;
    end
  end

  task automatic idle(input int n);
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input bit sof, input bit eol);
    bit ok = 0;
    int tries = 0;
    s_valid = 1'b1; s_sof = sof; s_eol = eol;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      tries++;
    end
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic send_line(input bit sof, input int n, input bit eol, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
      push(sof && i == 0, eol && i == n - 1);
    end
  endtask

  task automatic frame(input int h, input int gap_pct);
    for (int l = 0; l < h; l++) send_line(l == 0, LW, 1'b1, gap_pct);
  endtask

  task automatic clear_stats();
    win_cnt = 0; sof_cnt = 0; eol_cnt = 0; err_cnt = 0; held_cnt = 0; top_n = 0;
  endtask

  bit stop_rand = 0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready_low", s_ready, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("s_ready_before_first_edge", s_ready, 0);
    @(posedge clk); #1;
    check("s_ready_after_first_edge", s_ready, 1);

    // Pixels before any SOF are dropped.
    clear_stats();
    send_line(1'b0, 3, 1'b0, 0);
    idle(3);
    check("idle_drop_windows", win_cnt, 0);

    // Nominal 5-line frame.
    clear_stats();
    frame(5, 0);
    idle(12);
    check("nom_windows", win_cnt, 24);
    check("nom_sof", sof_cnt, 1);
    check("nom_eol", eol_cnt, 3);
    check("nom_err", err_cnt, 0);
    check("nom_top0", top_seq[0], 0);
    check("nom_top1", top_seq[1], 1);
    check("nom_top2", top_seq[2], 2);

    // Downstream stalls for 4 cycles mid-line.
    clear_stats();
    fork
      frame(5, 0);
      begin
        repeat (20) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle(12);
    check("bp_windows", win_cnt, 24);
    check("bp_held_cycles", held_cnt, 4);
    check("bp_eol", eol_cnt, 3);

    // Short line: EOL at column 5 of line 2.
    clear_stats();
    send_line(1'b1, LW, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    send_line(1'b0, 6, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    idle(12);
    check("short_windows", win_cnt, 22);
    check("short_err", err_cnt, 1);
    check("short_eol", eol_cnt, 3);

    // Long line: 10 pixels on line 3.
    clear_stats();
    send_line(1'b1, LW, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    send_line(1'b0, 10, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    idle(12);
    check("long_windows", win_cnt, 24);
    check("long_err", err_cnt, 1);

    // SOF arriving at column 3 of line 3.
    clear_stats();
    send_line(1'b1, LW, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    send_line(1'b0, 3, 1'b0, 0);
    frame(5, 0);
    idle(12);
    check("sofmid_windows", win_cnt, 34);
    check("sofmid_err", err_cnt, 1);
    check("sofmid_sof", sof_cnt, 2);
    check("sofmid_eol", eol_cnt, 4);

    // Asynchronous reset while in FLUSH.
    send_line(1'b1, LW, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    send_line(1'b0, LW, 1'b1, 0);
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    check("flush_en_rd", en_rd, 1);
    check("flush_read_x", read_x, LW - 1);
    check("flush_s_ready", s_ready, 0);
    #2 rstn = 1'b0;
    #1;
    check("arst_en_rd", en_rd, 0);
    check("arst_win_valid", win_valid, 0);
    check("arst_s_ready", s_ready, 0);
    check("arst_read_x", read_x, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);
    clear_stats();
    frame(5, 0);
    idle(12);
    check("post_rst_windows", win_cnt, 24);
    check("post_rst_sof", sof_cnt, 1);

    // Random frames, line lengths, source gaps and downstream stalls.
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          int h = 3 + int'($urandom_range(0, 3));
          for (int l = 0; l < h; l++) begin
            int r = int'($urandom_range(0, 9));
            int n = (r == 0) ? int'($urandom_range(1, LW - 1)) :
                    (r == 1) ? int'($urandom_range(LW + 1, LW + 3)) : LW;
            send_line(l == 0, n, 1'b1, 30);
          end
        end
        stop_rand = 1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #1 m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
